// File: rtl/player_id_lookup_ctrl.sv
// Player-ID ROM scan sequencer: walks the ROM from address 0 looking for a
// latched candidate ID, stopping on a match, the terminator word or the last entry.
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold the last scan
// WAIT   | rom_addr stable, counting ROM latency, compare on terminal count
// FINISH | one-cycle done pulse, then back to IDLE
module player_id_lookup_ctrl #(
   parameter int                ADDR_W      = 5,
   parameter int                DATA_W      = 16,
   parameter int                NUM_ENTRIES = 32,
   parameter int                ROM_LAT     = 2,
   parameter logic [DATA_W-1:0] EMPTY_CODE  = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] id_in,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W-1:0] index
);

   localparam int                CNT_W     = $clog2(ROM_LAT + 1);
   localparam logic [CNT_W-1:0]  CNT_TC    = CNT_W'(ROM_LAT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] id_lat, id_lat_nxt;
   logic [ADDR_W-1:0] addr_nxt, index_nxt;
   logic              found_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         id_lat   <= '0;
         rom_addr <= '0;
         found    <= 1'b0;
         index    <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         id_lat   <= id_lat_nxt;
         rom_addr <= addr_nxt;
         found    <= found_nxt;
         index    <= index_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      id_lat_nxt = id_lat;
      addr_nxt   = rom_addr;
      found_nxt  = found;
      index_nxt  = index;
      case (state)
         IDLE: begin
            if (start) begin
               found_nxt = 1'b0;
               index_nxt = '0;
               // an empty candidate can never match, so skip the ROM entirely
               if (id_in == EMPTY_CODE) begin
                  state_nxt = FINISH;
               end else begin
                  id_lat_nxt = id_in;
                  addr_nxt   = '0;
                  cnt_nxt    = '0;
                  state_nxt  = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt < CNT_TC) begin
               cnt_nxt = cnt + 1'b1;
            end else if (rom_q == id_lat) begin
               found_nxt = 1'b1;
               index_nxt = rom_addr;
               state_nxt = FINISH;
            end else if ((rom_q == EMPTY_CODE) || (rom_addr == LAST_ADDR)) begin
               state_nxt = FINISH;
            end else begin
               addr_nxt = rom_addr + 1'b1;
               cnt_nxt  = '0;
            end
         end
         FINISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == WAIT);
   assign done = (state == FINISH);

endmodule

// File: tb/tb_player_id_lookup_ctrl.sv
// Bench for player_id_lookup_ctrl: behavioural two-stage ROM, table-search
// reference model and directed plus randomized scan scenarios.
module tb_player_id_lookup_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] id_in = '0;
   logic [4:0]  rom_addr;
   logic [15:0] rom_q;
   logic        busy, done, found;
   logic [4:0]  index;

   int checks = 0;
   int errors = 0;

   logic [15:0] rom_tbl [32];
   logic [4:0]  rom_addr_r;

   player_id_lookup_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .id_in    (id_in),
      .rom_addr (rom_addr),
      .rom_q    (rom_q),
      .busy     (busy),
      .done     (done),
      .found    (found),
      .index    (index)
   );

   always #5 clk = ~clk;

   // address register then data register: two edges from stable address to q
   always @(posedge clk) begin
      rom_addr_r <= rom_addr;
      rom_q      <= rom_tbl[rom_addr_r];
   end

   task automatic load_default_table();
      for (int i = 0; i < 32; i++) rom_tbl[i] = 16'hFFFF;
      rom_tbl[0] = 16'hA1B2;
      rom_tbl[1] = 16'h1234;
      rom_tbl[2] = 16'h0BEE;
      rom_tbl[3] = 16'hCAFE;
      rom_tbl[4] = 16'h0000;
   endtask

   // Linear table search: result and the edge (after accept) of the final compare.
   function automatic void model(input logic [15:0] id, output logic f,
                                 output logic [4:0] idx, output int cmp_edge);
      f = 1'b0; idx = '0; cmp_edge = 96;
      if (id == 16'h0000) begin
         cmp_edge = 0;
         return;
      end
      for (int k = 0; k < 32; k++) begin
         if (rom_tbl[k] == id) begin
            f = 1'b1; idx = 5'(k); cmp_edge = (k + 1) * 3;
            return;
         end
         if (rom_tbl[k] == 16'h0000) begin
            cmp_edge = (k + 1) * 3;
            return;
         end
      end
   endfunction

   // Drives one request and monitors it; returns observations for the caller to judge.
   task automatic do_scan(input logic [15:0] id, input int repulse_at, input logic [15:0] repulse_id,
                          output int done_edge, output logic f, output logic [4:0] idx,
                          output logic [4:0] addr_end, output int addr_err, output int busy_err,
                          output logic done_after);
      int e;
      logic exp_busy;
      done_edge = -1; f = 1'b0; idx = '0; addr_end = '0;
      addr_err = 0; busy_err = 0; done_after = 1'b0;
      exp_busy = (id != 16'h0000);
      @(negedge clk);
      start = 1'b1; id_in = id;
      @(posedge clk);
      e = 0;
      @(negedge clk);
      while (e < 200) begin
         if (done) break;
         if (busy !== exp_busy) busy_err++;
         if (rom_addr !== 5'(e / 3)) addr_err++;
         start = (e == repulse_at);
         id_in = (e == repulse_at) ? repulse_id : 16'($urandom);
         @(posedge clk);
         e++;
         @(negedge clk);
      end
      start = 1'b0;
      if (done) begin
         done_edge = e;
         f = found; idx = index; addr_end = rom_addr;
         if (busy !== 1'b0) busy_err++;
         @(negedge clk);
         done_after = done;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({rom_addr, busy, done, found, index} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%0d busy=%b done=%b found=%b index=%0d, want all 0",
                  rom_addr, busy, done, found, index);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic run_and_check(input string name, input logic [15:0] id, input int repulse_at,
                                input logic [15:0] repulse_id, input logic [4:0] prior_addr);
      int de, ae, be, me;
      logic f, da, mf;
      logic [4:0] ix, aend, mi, exp_aend;
      model(id, mf, mi, me);
      do_scan(id, repulse_at, repulse_id, de, f, ix, aend, ae, be, da);
      exp_aend = (me == 0) ? prior_addr : 5'(me / 3 - 1);
      checks++;
      if (de != me) begin
         errors++;
         $display("FAIL %s done_edge: got %0d want %0d", name, de, me);
      end
      checks++;
      if ({f, ix} !== {mf, mi}) begin
         errors++;
         $display("FAIL %s result: got found=%b index=%0d want found=%b index=%0d", name, f, ix, mf, mi);
      end
      checks++;
      if (aend !== exp_aend || ae != 0) begin
         errors++;
         $display("FAIL %s rom_addr: end=%0d (want %0d), %0d off-sequence cycles", name, aend, exp_aend, ae);
      end
      checks++;
      if (be != 0 || da !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_done: %0d busy errors, done next cycle=%b want 0", name, be, da);
      end
   endtask

   task automatic test_match();
      logic [15:0] ids [4] = '{16'hA1B2, 16'hCAFE, 16'h1234, 16'h0BEE};
      for (int i = 0; i < 4; i++) run_and_check($sformatf("match_%h", ids[i]), ids[i], -1, 16'h0, rom_addr);
   endtask

   task automatic test_terminator();
      run_and_check("terminator_miss", 16'h5555, -1, 16'h0, rom_addr);
      @(negedge clk);
      checks++;
      if (rom_addr !== 5'd4) begin
         errors++;
         $display("FAIL terminator_addr_hold: got %0d want 4", rom_addr);
      end
   endtask

   task automatic test_full_miss();
      for (int i = 0; i < 32; i++) rom_tbl[i] = 16'hFFFF;
      run_and_check("full_miss", 16'h7777, -1, 16'h0, rom_addr);
      @(negedge clk);
      checks++;
      if (rom_addr !== 5'd31) begin
         errors++;
         $display("FAIL full_miss_no_wrap: got %0d want 31", rom_addr);
      end
      load_default_table();
   endtask

   task automatic test_empty_id();
      run_and_check("found_before_empty", 16'hCAFE, -1, 16'h0, rom_addr);
      run_and_check("empty_id", 16'h0000, -1, 16'h0, rom_addr);
   endtask

   task automatic test_restart_ignored();
      run_and_check("restart_ignored", 16'hCAFE, 4, 16'h1234, rom_addr);
   endtask

   task automatic test_back_to_back();
      int e, d1, d2;
      logic f1, f2;
      logic [4:0] i1, i2;
      d1 = -1; d2 = -1; f1 = 0; f2 = 0; i1 = 0; i2 = 0;
      @(negedge clk);
      start = 1'b1; id_in = 16'h0BEE;
      @(posedge clk);
      e = 0;
      @(negedge clk);
      id_in = 16'h1234;
      while (e < 60) begin
         if (done) begin
            if (d1 < 0) begin
               d1 = e; f1 = found; i1 = index;
            end else begin
               d2 = e; f2 = found; i2 = index;
               break;
            end
         end
         @(posedge clk);
         e++;
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (d1 != 9 || {f1, i1} !== {1'b1, 5'd2}) begin
         errors++;
         $display("FAIL b2b_first: edge=%0d found=%b index=%0d want edge=9 found=1 index=2", d1, f1, i1);
      end
      checks++;
      if (d2 != 17 || {f2, i2} !== {1'b1, 5'd1}) begin
         errors++;
         $display("FAIL b2b_second: edge=%0d found=%b index=%0d want edge=17 found=1 index=1", d2, f2, i2);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_scan();
      int saw_done;
      saw_done = 0;
      @(negedge clk);
      start = 1'b1; id_in = 16'h0BEE;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      checks++;
      if (rom_addr !== 5'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_state: addr=%0d busy=%b want addr=2 busy=1", rom_addr, busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rom_addr, busy, done, found, index} !== 13'd0) begin
         errors++;
         $display("FAIL async_reset: addr=%0d busy=%b done=%b found=%b index=%0d want all 0",
                  rom_addr, busy, done, found, index);
      end
      repeat (3) begin
         @(negedge clk);
         if (done) saw_done++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done) saw_done++;
      end
      checks++;
      if (saw_done != 0) begin
         errors++;
         $display("FAIL reset_no_done: done seen %0d cycles want 0", saw_done);
      end
      run_and_check("after_reset", 16'h1234, -1, 16'h0, rom_addr);
   endtask

   task automatic test_random();
      logic [15:0] id;
      for (int it = 0; it < 15; it++) begin
         for (int i = 0; i < 32; i++)
            rom_tbl[i] = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom_range(1, 40));
         if ($urandom_range(0, 1) == 1) id = rom_tbl[$urandom_range(0, 31)];
         else id = 16'($urandom_range(0, 45));
         run_and_check($sformatf("random_%0d", it), id, $urandom_range(0, 10), 16'($urandom), rom_addr);
      end
      load_default_table();
   endtask

   initial begin
      load_default_table();
      #1;
      test_reset();
      test_match();
      test_terminator();
      test_full_miss();
      test_empty_id();
      test_restart_ignored();
      test_back_to_back();
      test_reset_mid_scan();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/player_id_lookup_ctrl.md
Name: player_id_lookup_ctrl

Overview:
- Sequencer for the 32x16 player-ID ROM (PlayerIDROM_16: registered address in, 16-bit q out).
- On a start request it latches a 16-bit candidate ID, then scans ROM entries from address 0 upward until it finds a match, reaches the terminator code, or passes the last entry.
- Reports found/not-found and the matching index to the game-logic layer of the ID handler.
- The block is the sole driver of the ROM address bus.

Parameters:
- ADDR_W, 5, ROM address width.
- DATA_W, 16, ROM word width.
- NUM_ENTRIES, 32, number of scannable entries; must be at most 2^ADDR_W.
- ROM_LAT, 2, rising edges from a stable rom_addr to a valid rom_q; must be at least 1.
- EMPTY_CODE, 16'h0000, terminator word; marks the end of the valid table.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- id_in  in  DATA_W  candidate ID; latched on the accepted start.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  DATA_W  ROM data output.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle completion pulse.
- found  out  1  result of the last scan; held until the next accepted start.
- index  out  ADDR_W  matching address if found, else 0; held like found.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. rst_n low forces IDLE immediately. rom_addr=0, busy=0, done=0, found=0, index=0, wait counter=0, latched ID=0.
- Reset asserted mid-scan aborts the scan. No done pulse is issued.
- States: IDLE, WAIT, FINISH.
- IDLE, start=1, id_in != EMPTY_CODE:
  - Latch id_in; rom_addr<=0; cnt<=0.
  - found<=0; index<=0; busy<=1; go to WAIT.
- IDLE, start=1, id_in == EMPTY_CODE:
  - No ROM access; go to FINISH with found=0.
  - done pulses in the cycle after the next edge.
- WAIT:
  - cnt increments each edge while cnt < ROM_LAT.
  - At the edge where cnt == ROM_LAT, rom_q is compared against the latched ID.
- Compare outcome, evaluated in priority order:
  1. rom_q == latched ID: found<=1, index<=rom_addr, go to FINISH.
  2. rom_q == EMPTY_CODE: found<=0, go to FINISH.
  3. rom_addr == NUM_ENTRIES-1: found<=0, go to FINISH. The address never wraps.
  4. Otherwise: rom_addr<=rom_addr+1, cnt<=0, stay in WAIT.
- FINISH: done=1 and busy=0 for exactly one cycle, then return to IDLE. rom_addr holds its last value.
- Timing: for a match at index k, the compare occurs at edge (k+1)*(ROM_LAT+1) after the start-accept edge (edge 0). done is high in the cycle following the next edge.
- Timing with defaults: match at k takes 3(k+1) edges to the compare. A full miss compares at edge 96.
- start while busy or in FINISH is ignored. id_in changes after acceptance have no effect.
- start held high through FINISH into IDLE is accepted as a new request at the first IDLE edge.
- rom_addr is stable throughout each WAIT interval; it changes only on the advance edge.

Test Plan:
- Bench uses a behavioural ROM with ROM_LAT=2. Table: [0]=16'hA1B2, [1]=16'h1234, [2]=16'h0BEE, [3]=16'hCAFE, [4]=16'h0000, remainder 16'hFFFF.
- Match at 0: start with id_in=16'hA1B2 → compare at edge 3; done pulse one cycle; found=1, index=0; rom_addr never leaves 0.
- Match at 3: id_in=16'hCAFE → rom_addr sequences 0,1,2,3, each held 3 cycles; compare at edge 12; found=1, index=3; busy high from edge 0 until FINISH.
- Terminator miss: id_in=16'h5555 → scan stops at addr 4 (16'h0000) at edge 15; found=0, index=0; rom_addr never reaches 5.
- Full-table miss: table fully populated with 16'hFFFF, id_in=16'h7777 → 32 compares; done at the edge-96 compare; rom_addr ends at 31 with no wrap to 0.
- Edge cases:
  - id_in=16'h0000 → done within 2 cycles with found=0 and no rom_addr change.
  - start re-pulsed mid-scan with another ID → ignored; the original result is reported.
- Reset mid-scan: drop rst_n during the compare window of addr 2 → all outputs 0 asynchronously and no done pulse. After release, a new start with 16'h1234 → found=1, index=1.
